// File: rtl/alu_exec_seq.sv
// EX-stage ALU: single-cycle decode/execute plus a multi-cycle shift-add multu with HI/LO.
// Optional restoring divu is built only when DIVU_EN is defined.
module alu_exec_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic [2:0]       gout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
`ifdef DIVU_EN
        S_DIV,
`endif
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [2:0]         gout_q, gout_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   dec_res;
    logic [2:0]         dec_gout;
    logic               dec_err, dec_mul, dec_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;

    // Multiplier lives in the low half of acc; its LSB selects the add before each shift.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

`ifdef DIVU_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     div_top;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;

    assign div_top = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = (div_top >= {1'b0, mcand_q});
    assign div_rem = div_ge ? (div_top[WIDTH-1:0] - mcand_q) : div_top[WIDTH-1:0];
    assign acc_step = div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                            : {mul_sum, acc_q[WIDTH-1:1]};
`else
    assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    always_comb begin
        dec_res  = '0;
        dec_gout = 3'b010;
        dec_err  = 1'b0;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        case (aluop)
            2'b00: dec_res = a + b;
            2'b01: begin dec_res = a - b; dec_gout = 3'b110; end
            2'b11: begin dec_res = a | b; dec_gout = 3'b001; end
            default: begin
                case (funct)
                    6'b100000: dec_res = a + b;
                    6'b100010: begin dec_res = a - b;    dec_gout = 3'b110; end
                    6'b100100: begin dec_res = a & b;    dec_gout = 3'b000; end
                    6'b100101: begin dec_res = a | b;    dec_gout = 3'b001; end
                    6'b100111: begin dec_res = ~(a | b); dec_gout = 3'b101; end
                    6'b101010: begin
                        dec_res  = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                        dec_gout = 3'b111;
                    end
                    6'b011001: begin dec_mul = 1'b1; dec_gout = 3'b011; end
                    6'b010000: begin dec_res = hi_q; dec_gout = 3'b100; end
                    6'b010010: begin dec_res = lo_q; dec_gout = 3'b100; end
`ifdef DIVU_EN
                    6'b011011: begin dec_div = 1'b1; dec_gout = 3'b100; end
`endif
                    default:   dec_err = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        gout_d      = gout_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef DIVU_EN
        div_d       = div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    gout_d = dec_gout;
                    if (dec_mul || dec_div) begin
                        // W-1 steps in the busy state, the last one on the way out of DONE
                        state_d = dec_div ? state_t'(2) : S_MUL;
                        cnt_d   = CNT_W'(WIDTH - 2);
                        mcand_d = dec_div ? b : a;
                        acc_d   = {{WIDTH{1'b0}}, (dec_div ? a : b)};
`ifdef DIVU_EN
                        div_d   = dec_div;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = dec_res;
                        zero_d      = (dec_res == '0);
                        err_d       = dec_err;
                    end
                end
            end
            S_MUL
`ifdef DIVU_EN
            , S_DIV
`endif
            : begin
                acc_d = acc_step;
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                {hi_d, lo_d} = acc_step;
                out_valid_d  = 1'b1;
                result_d     = '0;
                zero_d       = 1'b1;
                err_d        = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            gout_q      <= 3'b000;
            hi_q        <= '0;
            lo_q        <= '0;
`ifdef DIVU_EN
            div_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            gout_q      <= gout_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef DIVU_EN
            div_q       <= div_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE) & ~reset;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign gout      = gout_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: vector table, multi-cycle corner sequences and
// randomized ops against a plain-arithmetic model (divu cases only when DIVU_EN is defined).
module tb_alu_exec_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [5:0]   funct = 6'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, zero, err;
    logic [W-1:0] result, hi, lo;
    logic [2:0]   gout;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    alu_exec_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .zero(zero), .err(err),
        .gout(gout), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   f;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic         e;
        logic [2:0]   g;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic ref_model(input logic [1:0] op, input logic [5:0] f,
                             input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] res, output logic e,
                             output logic [2:0] g, output logic multi);
        logic [63:0] p;
        res = '0; e = 1'b0; g = 3'b010; multi = 1'b0;
        case (op)
            2'd0: res = x + y;
            2'd1: begin res = x - y; g = 3'b110; end
            2'd3: begin res = x | y; g = 3'b001; end
            default: case (f)
                6'h20: res = x + y;
                6'h22: begin res = x - y; g = 3'b110; end
                6'h24: begin res = x & y; g = 3'b000; end
                6'h25: begin res = x | y; g = 3'b001; end
                6'h27: begin res = ~(x | y); g = 3'b101; end
                6'h2A: begin res = ($signed(x) < $signed(y)) ? 1 : 0; g = 3'b111; end
                6'h19: begin
                    p = {32'd0, x} * {32'd0, y};
                    m_hi = p[63:32]; m_lo = p[31:0]; g = 3'b011; multi = 1'b1;
                end
                6'h10: begin res = m_hi; g = 3'b100; end
                6'h12: begin res = m_lo; g = 3'b100; end
`ifdef DIVU_EN
                6'h1B: begin
                    if (y == 0) begin m_lo = '1; m_hi = x; end
                    else begin m_lo = x / y; m_hi = x % y; end
                    g = 3'b100; multi = 1'b1;
                end
`endif
                default: e = 1'b1;
            endcase
        endcase
    endtask

    // Issue one op, wait (bounded) for its out_valid, compare everything against the model.
    task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic ee, multi;
        logic [2:0] eg;
        int lat;
        ref_model(op, f, x, y, er, ee, eg, multi);
        @(negedge clk);
        in_valid = 1'b1; aluop = op; funct = f; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 2*W + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), multi ? 64'(W + 1) : 64'd1);
        chk({name, " result"}, 64'(result), 64'(er));
        chk({name, " zero"}, 64'(zero), 64'(er == 0));
        chk({name, " err"}, 64'(err), 64'(ee));
        chk({name, " gout"}, 64'(gout), 64'(eg));
        chk({name, " hi"}, 64'(hi), 64'(m_hi));
        chk({name, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    logic [5:0] legal_f[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h19, 6'h10, 6'h12, 6'h1B};

    initial begin
        int busy_bad;
        int ov_cnt;

        vecs[0]  = '{2'b10, 6'h20, 32'd7,        32'd5,        32'd12,       1'b0, 3'b010};
        vecs[1]  = '{2'b10, 6'h2A, 32'hFFFFFFFD, 32'd2,        32'd1,        1'b0, 3'b111};
        vecs[2]  = '{2'b10, 6'h22, 32'd4,        32'd4,        32'd0,        1'b0, 3'b110};
        vecs[3]  = '{2'b10, 6'h3F, 32'd9,        32'd3,        32'd0,        1'b1, 3'b010};
        vecs[4]  = '{2'b11, 6'h3F, 32'hF0,       32'h0F,       32'hFF,       1'b0, 3'b001};
        vecs[5]  = '{2'b00, 6'h22, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 3'b010};
        vecs[6]  = '{2'b01, 6'h20, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 3'b110};
        vecs[7]  = '{2'b10, 6'h24, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 3'b000};
        vecs[8]  = '{2'b10, 6'h27, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0, 3'b101};
        vecs[9]  = '{2'b10, 6'h2A, 32'd2,        32'hFFFFFFFD, 32'd0,        1'b0, 3'b111};
`ifdef DIVU_EN
        vecs[10] = '{2'b10, 6'h00, 32'd5,        32'd3,        32'd0,        1'b1, 3'b010};
`else
        vecs[10] = '{2'b10, 6'h1B, 32'd5,        32'd3,        32'd0,        1'b1, 3'b010};
`endif
        vecs[11] = '{2'b10, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 3'b111};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst release in_ready", 64'(in_ready), 64'd1);
        chk("rst result", 64'(result), 64'd0);
        chk("rst zero", 64'(zero), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst gout", 64'(gout), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);

        // Vector table, single-cycle ops
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; aluop = vecs[i].op; funct = vecs[i].f; a = vecs[i].x; b = vecs[i].y;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].res));
            chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].res == 0));
            chk($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].e));
            chk($sformatf("vec%0d gout", i), 64'(gout), 64'(vecs[i].g));
        end

        // Back-to-back accepts: slt then sub
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = 6'h2A; a = 32'hFFFFFFFD; b = 32'd2;
        @(posedge clk); #1;
        chk("b2b first valid", 64'(out_valid), 64'd1);
        chk("b2b first result", 64'(result), 64'd1);
        funct = 6'h22; a = 32'd4; b = 32'd4;
        @(posedge clk); #1;
        chk("b2b second valid", 64'(out_valid), 64'd1);
        chk("b2b second result", 64'(result), 64'd0);
        chk("b2b second zero", 64'(zero), 64'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle valid", 64'(out_valid), 64'd0);

        // multu with in_valid held during the busy window (must be ignored)
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = 6'h19; a = 32'hFFFFFFFF; b = 32'd2;
        @(posedge clk); #1;
        aluop = 2'b00; a = 32'd1; b = 32'd1;
        busy_bad = 0;
        for (int k = 0; k < W; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
            if (k >= 5) in_valid = 1'b0;
        end
        chk("multu busy window", 64'(busy_bad), 64'd0);
        @(posedge clk); #1;
        chk("multu out_valid", 64'(out_valid), 64'd1);
        chk("multu in_ready back", 64'(in_ready), 64'd1);
        chk("multu hi", 64'(hi), 64'd1);
        chk("multu lo", 64'(lo), 64'hFFFFFFFE);
        chk("multu result", 64'(result), 64'd0);
        chk("multu zero", 64'(zero), 64'd1);
        chk("multu gout", 64'(gout), 64'd3);
        m_hi = 32'd1; m_lo = 32'hFFFFFFFE;
        run_op("mfhi", 2'b10, 6'h10, 32'd0, 32'd0);
        run_op("mflo", 2'b10, 6'h12, 32'd0, 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = 6'h19; a = 32'h12345; b = 32'h777;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort in_ready during reset", 64'(in_ready), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort in_ready after", 64'(in_ready), 64'd1);
        ov_cnt = 0;
        for (int k = 0; k < 2*W; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) ov_cnt++;
        end
        chk("abort no out_valid", 64'(ov_cnt), 64'd0);
        m_hi = '0; m_lo = '0;

`ifdef DIVU_EN
        run_op("divu 17/5", 2'b10, 6'h1B, 32'd17, 32'd5);
        chk("divu 17/5 lo", 64'(lo), 64'd3);
        chk("divu 17/5 hi", 64'(hi), 64'd2);
        run_op("divu 9/0", 2'b10, 6'h1B, 32'd9, 32'd0);
        chk("divu 9/0 lo", 64'(lo), 64'hFFFFFFFF);
        chk("divu 9/0 hi", 64'(hi), 64'd9);
`endif

        // Randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [W-1:0] x, y;
            int r;
            r = $urandom_range(0, 9);
            op = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r == 2) ? 2'd3 : 2'd2;
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 9)];
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 5))
                0: x = '0;
                1: y = '1;
                2: y = 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), op, f, x, y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
